mem_stage_vec: RTL and testbench
================================

# mem_stage_vec

Memory-stage sequencer of the vector pipeline, the consumer of the EXE/MEM pipeline register's outputs. It executes scalar and vector loads/stores against a byte-wide synchronous data memory, one lane per cycle. It freezes upstream stages with `stall` while sequencing. It then presents a registered result, with the write-back controls, to the MEM/WB register.

## Interface
- `LANES`, 4, byte lanes per vector; vector width = LANES*8
- `ADDR_W`, 8, data-memory address width

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `sum_mem`  in  1  strided addressing request (see Configuration)
- `sel_mem`  in  1  1 = vector access (LANES lanes), 0 = scalar (lane 0 only)
- `sel_data`  in  1  store data source: 1 = `DATA1`, 0 = `inmediato` broadcast to every lane
- `mem_wr`  in  1  store operation
- `sel_wb`  in  1  1 = write-back from memory (load operation)
- `reg_wrv`, `reg_wrs`  in  1 each  vector/scalar register-file write enables, passed through
- `DATA1`  in  LANES*8  store data
- `ALU`  in  LANES*8  base address; only bits [ADDR_W-1:0] are used
- `dir_dest`  in  3  destination register, passed through
- `inmediato`  in  8  stride or immediate store byte
- `mem_addr`  out  ADDR_W  data-memory address
- `mem_wdata`  out  8  data-memory write byte
- `mem_we`  out  1  data-memory write enable
- `mem_rdata`  in  8  read byte, valid one cycle after its address
- `stall`  out  1  upstream must hold the EXE/MEM contents while high
- `result_out`  out  LANES*8  load data, or `ALU` for non-memory ops
- `dir_dest_out`, `sel_wb_out`, `reg_wrv_out`, `reg_wrs_out`  out  3/1/1/1  registered pass-through
- `out_valid`  out  1  one-cycle pulse; outputs above are valid

## Operation
- Memory op = `mem_wr | sel_wb`. If both are set, the op is a store and `sel_wb_out` is forced to 0.
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE, no memory op: at the edge, register `ALU`→`result_out` plus all pass-through fields, and pulse `out_valid`. State stays IDLE.
- IDLE, memory op: at the edge, capture all inputs, set lane=0, go to ACCESS.
- ACCESS, lane k:
  - `mem_addr = base + k*stride`, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
  - Store: `mem_we=1`; `mem_wdata` = lane k byte of the source, where lane k = bits [8k+7:8k].
  - Load: `mem_we=0`; the byte returned from lane k-1 is written into `result` lane k-1.
  - Last lane is LANES-1 for a vector op, 0 for a scalar op. On the last lane, a store goes to RESP and a load goes to DRAIN.
- DRAIN: capture the final byte, then go to RESP.
- RESP: pulse `out_valid` with the captured fields, then go to IDLE.
  - A scalar load zero-extends its byte into [7:0].
  - A store's `result_out` = captured `ALU`.
- `stall` is combinational: 1 in ACCESS and DRAIN, and 1 in IDLE while a memory op is present at the inputs. Otherwise 0.
- Upstream advances on the edge that leaves RESP.

## Timing
- Reset values: state IDLE, lane 0; every registered output is 0 (`result_out`, `mem_addr`, `mem_wdata`, pass-through fields, `out_valid`); `mem_we`=0; `stall`=0.
- Non-memory op: latency 1; throughput 1 per cycle.
- Scalar store: 3 cycles accept→`out_valid`. Scalar load: 4 cycles.
- Vector store: LANES+2 cycles. Vector load: LANES+3 cycles.
- Load read latency is exactly 1 cycle. `mem_rdata` is sampled only in ACCESS with lane>0, and in DRAIN.
- Input changes during ACCESS, DRAIN and RESP are ignored, because all fields were captured at accept.
- Reset mid-operation: `mem_we` drops immediately (asynchronously). Lanes already stored remain in memory, and no `out_valid` is issued for the aborted op.

## Configuration
- `MEM_STRIDE_EN` defined: stride = `inmediato` when `sum_mem`=1, otherwise 1. Stride 0 is legal and repeats the same address.
- Undefined: stride is always 1, and `sum_mem` is ignored.

## Test plan
- Non-memory op: `ALU`=0x12345678, `dir_dest`=5, `reg_wrv`=1 → next cycle `out_valid`=1, `result_out`=0x12345678, `dir_dest_out`=5, `stall` never high.
- Vector store: `DATA1`=0xDDCCBBAA, base 0x10, stride 1 → writes 0xAA@0x10, 0xBB@0x11, 0xCC@0x12, 0xDD@0x13 on consecutive cycles; `out_valid` 6 cycles after accept.
- Strided vector load (`MEM_STRIDE_EN`): base 0xFE, `inmediato`=2, memory bytes 0xFE=0x01, 0x00=0x02, 0x02=0x03, 0x04=0x04 → addresses wrap as shown, `result_out`=0x04030201.
- Scalar store with `sel_data`=0, `inmediato`=0x5A, base 0x20 → a single write of 0x5A@0x20; `stall` high for the accept and ACCESS cycles only.
- Scalar load of byte 0x80 → `result_out`=0x00000080, `sel_wb_out`=1.
- Reset asserted in vector-store lane 2 → `mem_we` falls without waiting for a clock, lanes 0–1 are written, lane 3 is untouched, there is no `out_valid`, and state is IDLE after release.

Source files
------------

// File: rtl/mem_stage_vec.sv
// mem_stage_vec: memory-stage sequencer of the vector pipeline.
// Runs scalar/vector loads and stores against a byte-wide synchronous data
// memory one lane per cycle, stalling upstream while it sequences, then
// presents a registered result plus write-back controls to MEM/WB.
// Optional feature: define MEM_STRIDE_EN to enable strided addressing
// (stride = inmediato when sum_mem=1); otherwise the stride is always 1.
module mem_stage_vec #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sum_mem,
    input  logic                 sel_mem,
    input  logic                 sel_data,
    input  logic                 mem_wr,
    input  logic                 sel_wb,
    input  logic                 reg_wrv,
    input  logic                 reg_wrs,
    input  logic [LANES*8-1:0]   DATA1,
    input  logic [LANES*8-1:0]   ALU,
    input  logic [2:0]           dir_dest,
    input  logic [7:0]           inmediato,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    input  logic [7:0]           mem_rdata,
    output logic                 stall,
    output logic [LANES*8-1:0]   result_out,
    output logic [2:0]           dir_dest_out,
    output logic                 sel_wb_out,
    output logic                 reg_wrv_out,
    output logic                 reg_wrs_out,
    output logic                 out_valid
);

    localparam int W  = LANES * 8;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t            r_state;
    logic [LW-1:0]     r_lane;
    logic              r_vec;
    logic              r_store;
    logic              r_wb;
    logic              r_wrv;
    logic              r_wrs;
    logic [2:0]        r_dir;
    logic [W-1:0]      r_alu;
    logic [W-1:0]      r_sdata;
    logic [W-1:0]      r_load;
    logic [ADDR_W-1:0] r_stride;

    logic              w_memop;
    logic              w_wb;
    logic [W-1:0]      w_src;
    logic [ADDR_W-1:0] w_stride;
    logic [LW-1:0]     w_last;
    logic [LW-1:0]     w_lane_nxt;
    logic [LW-1:0]     w_lane_prv;
    logic              w_is_last;

    assign w_memop    = mem_wr | sel_wb;
    // A combined store+load request is treated as a store: no memory write-back.
    assign w_wb       = sel_wb & ~mem_wr;
    assign w_src      = sel_data ? DATA1 : {LANES{inmediato}};
    assign w_last     = r_vec ? LW'(LANES - 1) : '0;
    assign w_is_last  = (r_lane == w_last);
    assign w_lane_nxt = r_lane + 1'b1;
    assign w_lane_prv = r_lane - 1'b1;

`ifdef MEM_STRIDE_EN
    assign w_stride = sum_mem ? ADDR_W'(inmediato) : ADDR_W'(1);
`else
    logic w_unused_sum;
    assign w_unused_sum = sum_mem;
    assign w_stride     = ADDR_W'(1);
`endif

    // Upstream freeze: held while sequencing and while a memory op waits in IDLE.
    assign stall = (r_state == ACCESS) || (r_state == DRAIN) ||
                   ((r_state == IDLE) && w_memop);

    // Sequencer FSM with registered memory port and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_vec        <= 1'b0;
            r_store      <= 1'b0;
            r_wb         <= 1'b0;
            r_wrv        <= 1'b0;
            r_wrs        <= 1'b0;
            r_dir        <= '0;
            r_alu        <= '0;
            r_sdata      <= '0;
            r_load       <= '0;
            r_stride     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            result_out   <= '0;
            dir_dest_out <= '0;
            sel_wb_out   <= 1'b0;
            reg_wrv_out  <= 1'b0;
            reg_wrs_out  <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_memop) begin
                        r_vec     <= sel_mem;
                        r_store   <= mem_wr;
                        r_wb      <= w_wb;
                        r_wrv     <= reg_wrv;
                        r_wrs     <= reg_wrs;
                        r_dir     <= dir_dest;
                        r_alu     <= ALU;
                        r_sdata   <= w_src;
                        r_load    <= '0;
                        r_stride  <= w_stride;
                        r_lane    <= '0;
                        mem_addr  <= ALU[ADDR_W-1:0];
                        mem_wdata <= w_src[7:0];
                        mem_we    <= mem_wr;
                        r_state   <= ACCESS;
                    end else begin
                        result_out   <= ALU;
                        dir_dest_out <= dir_dest;
                        sel_wb_out   <= w_wb;
                        reg_wrv_out  <= reg_wrv;
                        reg_wrs_out  <= reg_wrs;
                        out_valid    <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Byte returned now belongs to the address issued last cycle.
                    if (!r_store && (r_lane != '0))
                        r_load[{w_lane_prv, 3'b000} +: 8] <= mem_rdata;
                    if (w_is_last) begin
                        mem_we  <= 1'b0;
                        r_state <= r_store ? RESP : DRAIN;
                    end else begin
                        r_lane    <= w_lane_nxt;
                        mem_addr  <= mem_addr + r_stride;
                        mem_wdata <= r_sdata[{w_lane_nxt, 3'b000} +: 8];
                    end
                end
                DRAIN: begin
                    r_load[{r_lane, 3'b000} +: 8] <= mem_rdata;
                    r_state <= RESP;
                end
                RESP: begin
                    result_out   <= r_store ? r_alu : r_load;
                    dir_dest_out <= r_dir;
                    sel_wb_out   <= r_wb;
                    reg_wrv_out  <= r_wrv;
                    reg_wrs_out  <= r_wrs;
                    out_valid    <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_vec.sv
// Scoreboard bench for mem_stage_vec with a behavioural byte memory.
module tb_mem_stage_vec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sum_mem = 0, sel_mem = 0, sel_data = 0, mem_wr = 0, sel_wb = 0;
    logic        reg_wrv = 0, reg_wrs = 0;
    logic [31:0] DATA1 = '0, ALU = '0;
    logic [2:0]  dir_dest = '0;
    logic [7:0]  inmediato = '0;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, stall, out_valid;
    logic [31:0] result_out;
    logic [2:0]  dir_dest_out;
    logic        sel_wb_out, reg_wrv_out, reg_wrs_out;

    mem_stage_vec #(.LANES(4), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sum_mem(sum_mem), .sel_mem(sel_mem),
        .sel_data(sel_data), .mem_wr(mem_wr), .sel_wb(sel_wb),
        .reg_wrv(reg_wrv), .reg_wrs(reg_wrs), .DATA1(DATA1), .ALU(ALU),
        .dir_dest(dir_dest), .inmediato(inmediato), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stall(stall), .result_out(result_out), .dir_dest_out(dir_dest_out),
        .sel_wb_out(sel_wb_out), .reg_wrv_out(reg_wrv_out),
        .reg_wrs_out(reg_wrs_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  dir;
        logic        wb, wrv, wrs;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wexp_t;

    exp_t  sq[$];
    wexp_t wq[$];
    exp_t  sb_e;
    wexp_t sb_w;

    // Behavioural synchronous byte memory, read data one cycle after address.
    logic [7:0] mem [256];
    logic       mem_init = 1'b0;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h40: return 8'h80;
            'hFE: return 8'h01;
            'hFF: return 8'h11;
            'h00: return 8'h02;
            'h01: return 8'h12;
            'h02: return 8'h03;
            'h04: return 8'h04;
            'h30, 'h31, 'h32, 'h33: return 8'hEE;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (sq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_out_valid: got result %0h, want none", result_out);
            end else begin
                sb_e = sq.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(sb_e.cyc));
                chk("resp_result", 64'(result_out), 64'(sb_e.res));
                chk("resp_ctrl", {dir_dest_out, sel_wb_out, reg_wrv_out, reg_wrs_out},
                    {sb_e.dir, sb_e.wb, sb_e.wrv, sb_e.wrs});
            end
        end
    end

    // Memory write monitor.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: got %0h@%0h, want none", mem_wdata, mem_addr);
            end else begin
                sb_w = wq.pop_front();
                chk("mem_write", {mem_addr, mem_wdata}, {sb_w.addr, sb_w.data});
            end
        end
    end

    task automatic wr_exp(input logic [7:0] a, input logic [7:0] d);
        wexp_t w;
        w.addr = a; w.data = d;
        wq.push_back(w);
    endtask

    // Presents one instruction and holds it until upstream may advance.
    task automatic send(input logic [31:0] alu, input logic [31:0] d1,
                        input logic [7:0] imm, input logic [2:0] dir,
                        input logic vec, input logic sd, input logic wr,
                        input logic wb, input logic wrv, input logic wrs,
                        input logic sm, input logic [31:0] exp_res,
                        input logic exp_wb, input int lat, input int exp_stall);
        exp_t e;
        int   n;
        @(negedge clk);
        ALU = alu; DATA1 = d1; inmediato = imm; dir_dest = dir;
        sel_mem = vec; sel_data = sd; mem_wr = wr; sel_wb = wb;
        reg_wrv = wrv; reg_wrs = wrs; sum_mem = sm;
        e.res = exp_res; e.dir = dir; e.wb = exp_wb; e.wrv = wrv; e.wrs = wrs;
        e.cyc = cyc + lat;
        sq.push_back(e);
        #1;
        mon_en = 1'b1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
            // Operands after accept must have no effect.
            if (wr | wb) begin
                ALU = $urandom; DATA1 = $urandom; inmediato = 8'($urandom);
                dir_dest = 3'($urandom);
            end
            #1;
        end
        chk("stall_cycles", 64'(n), 64'(exp_stall));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        chk("rst_result", 64'(result_out), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_we", 64'(mem_we), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_wdata", 64'(mem_wdata), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_ctrl", {dir_dest_out, sel_wb_out, reg_wrv_out, reg_wrs_out}, 6'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //   alu           data1         imm    dir  vec sd wr wb wrv wrs sm  exp_res      wb lat st
        send(32'h12345678, 32'h0,        8'h00, 3'd5, 0, 0, 0, 0, 1, 0, 0, 32'h12345678, 0, 1, 0);
        send(32'hA5A50F0F, 32'h0,        8'h00, 3'd7, 0, 0, 0, 0, 0, 1, 0, 32'hA5A50F0F, 0, 1, 0);

        wr_exp(8'h10, 8'hAA); wr_exp(8'h11, 8'hBB); wr_exp(8'h12, 8'hCC); wr_exp(8'h13, 8'hDD);
        send(32'h00000010, 32'hDDCCBBAA, 8'h00, 3'd2, 1, 1, 1, 0, 0, 0, 0, 32'h00000010, 0, 6, 5);

        wr_exp(8'h20, 8'h5A);
        send(32'h00000020, 32'h99887766, 8'h5A, 3'd1, 0, 0, 1, 0, 0, 0, 0, 32'h00000020, 0, 3, 2);

        send(32'h00000040, 32'h0,        8'h00, 3'd3, 0, 0, 0, 1, 0, 1, 0, 32'h00000080, 1, 4, 3);

        send(32'h00000010, 32'h0,        8'h00, 3'd4, 1, 0, 0, 1, 1, 0, 0, 32'hDDCCBBAA, 1, 7, 6);

        // Store and load both requested: treated as a store, upper ALU bits ignored.
        wr_exp(8'h50, 8'h77);
        send(32'hFFFF0050, 32'h00000077, 8'h00, 3'd6, 0, 1, 1, 1, 0, 1, 0, 32'hFFFF0050, 0, 3, 2);

`ifdef MEM_STRIDE_EN
        send(32'h000000FE, 32'h0,        8'h02, 3'd0, 1, 0, 0, 1, 1, 0, 1, 32'h04030201, 1, 7, 6);
`else
        send(32'h000000FE, 32'h0,        8'h02, 3'd0, 1, 0, 0, 1, 1, 0, 1, 32'h12021101, 1, 7, 6);
`endif

        wr_exp(8'h60, 8'h3C); wr_exp(8'h61, 8'h3C); wr_exp(8'h62, 8'h3C); wr_exp(8'h63, 8'h3C);
        send(32'h00000060, 32'h12345678, 8'h3C, 3'd5, 1, 0, 1, 0, 1, 1, 0, 32'h00000060, 0, 6, 5);

        send(32'h0BADBEEF, 32'h0,        8'h00, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADBEEF, 0, 1, 0);

        for (int i = 0; i < 50 && sq.size() != 0; i++) @(posedge clk);
        chk("sb_drained", 64'(sq.size()), 64'h0);
        mon_en = 1'b0;
        chk("writes_drained", 64'(wq.size()), 64'h0);

        // Reset during lane 2 of a vector store.
        @(negedge clk);
        ALU = 32'h30; DATA1 = 32'h44332211; sel_mem = 1; sel_data = 1;
        mem_wr = 1; sel_wb = 0; sum_mem = 0; reg_wrv = 1; reg_wrs = 0;
        wr_exp(8'h30, 8'h11); wr_exp(8'h31, 8'h22);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_we", 64'(mem_we), 64'h1);
        chk("pre_rst_addr", 64'(mem_addr), 64'h32);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(mem_we), 64'h0);
        chk("rst_mid_valid", 64'(out_valid), 64'h0);
        mem_wr = 0; sel_mem = 0; ALU = 32'hCAFEF00D; dir_dest = 3'd6;
        #1;
        chk("rst_mid_stall", 64'(stall), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", 64'(out_valid), 64'h0);
        chk("rst_lanes", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'h1122EEEE);
        chk("rst_writes", 64'(wq.size()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'h1);
        chk("post_rst_result", 64'(result_out), 64'hCAFEF00D);
        chk("post_rst_dir", 64'(dir_dest_out), 64'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
